lsu_ctrl: RTL and testbench

Multi-cycle load/store controller between the execute stage and the data-memory port. Accepts one access per handshake, aligns address and store data to the 32-bit word, generates the byte mask, issues one request to memory, then sign/zero-extends the load result and hands it to write-back. Replaces the fixed single-cycle memory timing with a valid/ready handshake, so the memory side can add wait states.

---
 rtl/lsu_ctrl_pkg.sv | 29 ++
 rtl/lsu_ctrl_if.sv | 52 +++++
 rtl/lsu_lane_align.sv | 50 +++++
 rtl/lsu_ctrl.sv | 116 +++++++++++
 tb/tb_lsu_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store controller: access direction, size, sign
// select, FSM states and the misalignment predicate.
package lsu_ctrl_pkg;

  localparam logic       MEM_READ          = 1'b0;
  localparam logic       MEM_WRITE         = 1'b1;
  localparam logic [1:0] DATASIZE_BYTE     = 2'b00;
  localparam logic [1:0] DATASIZE_HALFWORD = 2'b01;
  localparam logic [1:0] DATASIZE_WORD     = 2'b10;
  localparam logic       TYPE_UNSIGNED     = 1'b0;
  localparam logic       TYPE_SIGNED       = 1'b1;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Size 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
    case (size)
      DATASIZE_BYTE:     return 1'b0;
      DATASIZE_HALFWORD: return off[0];
      default:           return (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bundle of the execute-side, memory-side and write-back-side signals of lsu_ctrl.
// slave = the controller, master = its environment (execute, memory, write-back).
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Every channel transfers on a rising edge where its valid and ready are both
  // high; valid, once raised, holds its payload stable until that edge.
  // mem_resp_valid is a single-cycle pulse with no ready.
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic              in_memrw;
  logic [1:0]        in_datasize;
  logic              in_issigned;
  logic [4:0]        in_rd;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [4:0]        out_rd;
  logic              out_err;

  modport slave (
    input  in_valid, in_addr, in_wdata, in_memrw, in_datasize, in_issigned, in_rd,
    output in_ready,
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output out_valid, out_data, out_rd, out_err,
    input  out_ready
  );

  modport master (
    output in_valid, in_addr, in_wdata, in_memrw, in_datasize, in_issigned, in_rd,
    input  in_ready,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  out_valid, out_data, out_rd, out_err,
    output out_ready
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: store data shift and write mask, load extract
// and sign/zero extension. Offsets are forced to the access's natural alignment.
module lsu_lane_align
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        issigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [1:0]  off_eff;
  logic [4:0]  shamt;
  logic [31:0] rd_shift;

  always_comb begin
    case (size_i)
      DATASIZE_BYTE:     off_eff = off_i;
      DATASIZE_HALFWORD: off_eff = {off_i[1], 1'b0};
      default:           off_eff = 2'b00;
    endcase
  end

  assign shamt    = {off_eff, 3'b000};
  assign rd_shift = rdata_i >> shamt;

  always_comb begin
    wmask_o = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      DATASIZE_BYTE: begin
        wmask_o = 4'b0001 << off_eff;
        wdata_o = {24'd0, wdata_i[7:0]} << shamt;
        rdata_o = {{24{issigned_i & rd_shift[7]}}, rd_shift[7:0]};
      end
      DATASIZE_HALFWORD: begin
        wmask_o = 4'b0011 << off_eff;
        wdata_o = {16'd0, wdata_i[15:0]} << shamt;
        rdata_o = {{16{issigned_i & rd_shift[15]}}, rd_shift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store controller: IDLE -> REQ -> WAIT -> DONE, one access at a time.
// Optional macro LSU_MISALIGN_CHECK_EN reports misaligned accesses via out_err instead of issuing them.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  lsu_ctrl_if.slave  bus,
  output lsu_state_e dbg_state_o
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              memrw_q, issigned_q, err_q;
  logic [1:0]        size_q;
  logic [4:0]        rd_q;
  logic              misalign;
  logic              accept;
  logic [3:0]        wmask;
  logic [31:0]       wdata_sh, rdata_ext;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = is_misaligned(bus.in_addr[1:0], bus.in_datasize);
`else
  assign misalign = 1'b0;
`endif

  assign accept      = (state_q == LSU_IDLE) && bus.in_valid;
  assign dbg_state_o = state_q;

  lsu_lane_align u_align (
    .off_i      (addr_q[1:0]),
    .size_i     (size_q),
    .issigned_i (issigned_q),
    .wdata_i    (wdata_q),
    .rdata_i    (rdata_q),
    .wmask_o    (wmask),
    .wdata_o    (wdata_sh),
    .rdata_o    (rdata_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LSU_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      memrw_q    <= MEM_READ;
      issigned_q <= TYPE_UNSIGNED;
      err_q      <= 1'b0;
      size_q     <= DATASIZE_BYTE;
      rd_q       <= '0;
    end else begin
      if (accept) begin
        addr_q     <= bus.in_addr;
        wdata_q    <= bus.in_wdata;
        memrw_q    <= bus.in_memrw;
        size_q     <= bus.in_datasize;
        issigned_q <= bus.in_issigned;
        rd_q       <= bus.in_rd;
        err_q      <= misalign;
      end
      if (state_q == LSU_WAIT && bus.mem_resp_valid && memrw_q == MEM_READ)
        rdata_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    state_d           = state_q;
    bus.in_ready      = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
    bus.mem_wdata     = '0;
    bus.mem_wmask     = 4'b0000;
    bus.out_valid     = 1'b0;
    bus.out_data      = '0;
    bus.out_rd        = rd_q;
    bus.out_err       = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = misalign ? LSU_DONE : LSU_REQ;
      end
      LSU_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_we        = memrw_q;
        if (memrw_q == MEM_WRITE) begin
          bus.mem_wdata = wdata_sh;
          bus.mem_wmask = wmask;
        end
        if (bus.mem_req_ready) state_d = LSU_WAIT;
      end
      LSU_WAIT: begin
        if (bus.mem_resp_valid) state_d = LSU_DONE;
      end
      LSU_DONE: begin
        bus.out_valid = 1'b1;
        bus.out_err   = err_q;
        // Stores and rejected accesses return zero data.
        if (memrw_q == MEM_READ && !err_q) bus.out_data = rdata_ext;
        if (bus.out_ready) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized accesses
// scored against an arithmetic reference model.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [4:0]  rd;
    logic [31:0] rdata;
  } access_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  lsu_state_e dbg_state;
  int         chk_cnt = 0;
  int         err_cnt = 0;
  logic [37:0] exp_q[$];

  lsu_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned m_off(access_t a);
    int unsigned o = a.addr % 4;
    if (a.size == 2'd0) return o;
    if (a.size == 2'd1) return (o / 2) * 2;
    return 0;
  endfunction

  function automatic logic m_err(access_t a);
`ifdef LSU_MISALIGN_CHECK_EN
    if (a.size == 2'd1) return (a.addr % 2) != 0;
    if (a.size >= 2'd2) return (a.addr % 4) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_mask(access_t a);
    if (!a.rw) return 4'd0;
    if (a.size == 2'd0) return 4'(1 << m_off(a));
    if (a.size == 2'd1) return 4'(3 << m_off(a));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(access_t a);
    if (!a.rw) return 32'd0;
    if (a.size == 2'd0) return (a.wdata & 32'hFF) << (8 * m_off(a));
    if (a.size == 2'd1) return (a.wdata & 32'hFFFF) << (8 * m_off(a));
    return a.wdata;
  endfunction

  function automatic logic [31:0] m_out(access_t a);
    logic [31:0] v;
    if (a.rw || m_err(a)) return 32'd0;
    v = a.rdata >> (8 * m_off(a));
    if (a.size == 2'd0) begin
      v = v & 32'hFF;
      if (a.sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (a.size == 2'd1) begin
      v = v & 32'hFFFF;
      if (a.sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
      return v;
    end
    return a.rdata;
  endfunction

  function automatic logic [37:0] m_result(access_t a);
    return {m_err(a), a.rd, m_out(a)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic present(access_t a);
    bus.in_valid    = 1'b1;
    bus.in_addr     = a.addr;
    bus.in_wdata    = a.wdata;
    bus.in_memrw    = a.rw;
    bus.in_datasize = a.size;
    bus.in_issigned = a.sgn;
    bus.in_rd       = a.rd;
  endtask

  task automatic send(access_t a, input bit hold);
    @(negedge clk);
    present(a);
    check("in_ready_idle", 38'(bus.in_ready), 38'd1);
    @(posedge clk);
    exp_q.push_back(m_result(a));
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic check_req(access_t a);
    check("mem_req_valid", 38'(bus.mem_req_valid), 38'd1);
    check("mem_addr", 38'(bus.mem_addr), 38'(a.addr & 32'hFFFF_FFFC));
    check("mem_we", 38'(bus.mem_we), 38'(a.rw));
    check("mem_wmask", 38'(bus.mem_wmask), 38'(m_mask(a)));
    check("mem_wdata", 38'(bus.mem_wdata), 38'(m_wdata(a)));
    check("in_ready_busy", 38'(bus.in_ready), 38'd0);
  endtask

  // Called at the negedge after accept; returns at the negedge after the response.
  task automatic serve_mem(access_t a, input int stall, input int resp_dly);
    if (m_err(a)) begin
      check("no_mem_req", 38'(bus.mem_req_valid), 38'd0);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      check_req(a);
      bus.mem_req_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    check_req(a);
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("req_dropped", 38'(bus.mem_req_valid), 38'd0);
    for (int i = 0; i < resp_dly; i++) begin
      check("out_valid_early", 38'(bus.out_valid), 38'd0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = a.rdata;
    @(posedge clk);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = $urandom;
  endtask

  // Scoreboard side: the head of exp_q must be presented until out_ready.
  task automatic drain_out(input int stall);
    logic [37:0] exp;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 38'd1, 38'd0);
      return;
    end
    exp = exp_q[0];
    for (int i = 0; i < stall; i++) begin
      check("out_valid_hold", 38'(bus.out_valid), 38'd1);
      check("out_result_hold", {bus.out_err, bus.out_rd, bus.out_data}, exp);
      check("in_ready_done", 38'(bus.in_ready), 38'd0);
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    check("out_valid", 38'(bus.out_valid), 38'd1);
    check("out_result", {bus.out_err, bus.out_rd, bus.out_data}, exp);
    bus.out_ready = 1'b1;
    @(posedge clk);
    void'(exp_q.pop_front());
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_drop", 38'(bus.out_valid), 38'd0);
    check("in_ready_back", 38'(bus.in_ready), 38'd1);
  endtask

  task automatic run_access(access_t a, input int req_stall, input int resp_dly, input int out_stall);
    send(a, 1'b0);
    serve_mem(a, req_stall, resp_dly);
    drain_out(out_stall);
  endtask

  function automatic access_t mk(logic [31:0] addr, logic [31:0] wdata, logic rw,
                                 logic [1:0] size, logic sgn, logic [4:0] rd, logic [31:0] rdata);
    access_t a;
    a.addr = addr; a.wdata = wdata; a.rw = rw; a.size = size;
    a.sgn = sgn; a.rd = rd; a.rdata = rdata;
    return a;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    access_t a, b;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_wdata = '0; bus.in_memrw = 1'b0;
    bus.in_datasize = 2'd0; bus.in_issigned = 1'b0; bus.in_rd = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 38'(bus.in_ready), 38'd1);
    check("rst_mem_req_valid", 38'(bus.mem_req_valid), 38'd0);
    check("rst_mem_we", 38'(bus.mem_we), 38'd0);
    check("rst_mem_addr", 38'(bus.mem_addr), 38'd0);
    check("rst_mem_wdata", 38'(bus.mem_wdata), 38'd0);
    check("rst_mem_wmask", 38'(bus.mem_wmask), 38'd0);
    check("rst_out_valid", 38'(bus.out_valid), 38'd0);
    check("rst_out", {bus.out_err, bus.out_rd, bus.out_data}, 38'd0);
    check("rst_state", 38'(dbg_state), 38'(LSU_IDLE));
    rst = 1'b0;

    // Store byte to lane 3.
    run_access(mk(32'h8000_0003, 32'h0000_00AB, MEM_WRITE, DATASIZE_BYTE, 1'b0, 5'd3, 32'h0), 0, 0, 0);
    // Halfword loads, signed and unsigned.
    run_access(mk(32'h8000_0002, 32'h0, MEM_READ, DATASIZE_HALFWORD, TYPE_SIGNED, 5'd7, 32'h8001_1234), 0, 0, 0);
    run_access(mk(32'h8000_0002, 32'h0, MEM_READ, DATASIZE_HALFWORD, TYPE_UNSIGNED, 5'd8, 32'h8001_1234), 0, 0, 0);
    // Signed byte with request and write-back back-pressure.
    run_access(mk(32'h8000_0001, 32'h0, MEM_READ, DATASIZE_BYTE, TYPE_SIGNED, 5'd9, 32'h0000_7F00), 3, 0, 2);
    // Word load from an address with a non-zero offset.
    run_access(mk(32'h8000_0006, 32'h0, MEM_READ, DATASIZE_WORD, TYPE_UNSIGNED, 5'd10, 32'hDEAD_BEEF), 0, 1, 0);
    // Size 2'b11 behaves as a word store.
    run_access(mk(32'h8000_0010, 32'h1234_5678, MEM_WRITE, 2'b11, 1'b0, 5'd11, 32'h0), 1, 0, 1);

    // Reset while waiting for the memory response.
    a = mk(32'h8000_0020, 32'h0, MEM_READ, DATASIZE_WORD, TYPE_UNSIGNED, 5'd12, 32'h5555_AAAA);
    send(a, 1'b0);
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("pre_rst_state", 38'(dbg_state), 38'(LSU_WAIT));
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", 38'(bus.mem_req_valid), 38'd0);
    check("async_rst_out", 38'(bus.out_valid), 38'd0);
    check("async_rst_ready", 38'(bus.in_ready), 38'd1);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("stray_resp_out", 38'(bus.out_valid), 38'd0);
    check("stray_resp_out_data", 38'(bus.out_data), 38'd0);
    check("stray_resp_state", 38'(dbg_state), 38'(LSU_IDLE));

    // Back-to-back with in_valid held: load accepted only after the store's out handshake.
    a = mk(32'h8000_0041, 32'h0000_00C3, MEM_WRITE, DATASIZE_BYTE, 1'b0, 5'd13, 32'h0);
    b = mk(32'h8000_0044, 32'h0, MEM_READ, DATASIZE_HALFWORD, TYPE_SIGNED, 5'd14, 32'h0000_F00D);
    send(a, 1'b1);
    present(b);
    serve_mem(a, 1, 0);
    drain_out(1);
    check("b2b_not_yet_accepted", 38'(dbg_state), 38'(LSU_IDLE));
    @(posedge clk);
    exp_q.push_back(m_result(b));
    @(negedge clk);
    bus.in_valid = 1'b0;
    serve_mem(b, 0, 0);
    drain_out(0);

    // Randomized accesses.
    for (int n = 0; n < 60; n++) begin
      a = mk(32'h8000_0000 + $urandom_range(0, 1023), $urandom, 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      run_access(a, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    check("exp_q_drained", 38'(exp_q.size()), 38'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
